// File: rtl/atsc_conv_deint.sv
// Convolutional deinterleaver: B branches with delays (B-1-i)*M stored in one shared RAM,
// preceded by a post-reset memory clear sweep.
//   state    | meaning
//   ST_CLEAR | writing zeros over the whole delay-line RAM, input stalled
//   ST_RUN   | accepting beats, commutator advancing per non-bypass beat
module atsc_conv_deint #(
    parameter int WIDTH     = 32,
    parameter int BRANCHES  = 52,
    parameter int DEPTH_INC = 4
) (
    input  logic                        ce_clk,
    input  logic                        ce_rst,
    input  logic [WIDTH-1:0]            i_tdata,
    input  logic                        i_tvalid,
    input  logic                        i_tlast,
    output logic                        i_tready,
    output logic [WIDTH-1:0]            o_tdata,
    output logic                        o_tvalid,
    output logic                        o_tlast,
    input  logic                        o_tready,
    input  logic                        cfg_bypass,
    input  logic                        cfg_resync,
    output logic                        stat_clearing,
    output logic [$clog2(BRANCHES)-1:0] stat_branch,
    output logic [15:0]                 stat_sync_err
);
    localparam int TOTAL = DEPTH_INC * BRANCHES * (BRANCHES - 1) / 2;
    localparam int AW    = $clog2(TOTAL + 1);
    localparam int BW    = $clog2(BRANCHES);
    localparam logic [BW-1:0] LAST_BR   = BW'(BRANCHES - 1);
    localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL - 1);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t           state_q;
    logic [AW-1:0]    clr_addr_q;
    logic [BW-1:0]    branch_q;
    logic [AW-1:0]    ptr_q [BRANCHES];
    logic [15:0]      sync_err_q;
    logic             o_tvalid_q;
    logic             o_tlast_q;
    logic             sel_ram_q;
    logic [WIDTH-1:0] dat_q;
    logic [WIDTH-1:0] ram_rd_q;
    logic [WIDTH-1:0] mem [TOTAL];

    logic [AW-1:0]    base_c  [BRANCHES];
    logic [AW-1:0]    depth_c [BRANCHES];

    for (genvar g = 0; g < BRANCHES; g++) begin : g_tab
        assign base_c[g]  = AW'(DEPTH_INC * (g * (BRANCHES - 1) - (g * (g - 1)) / 2));
        assign depth_c[g] = AW'((BRANCHES - 1 - g) * DEPTH_INC);
    end

    logic             accept;
    logic             ram_beat;
    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [AW-1:0]    cur_base;
    logic [AW-1:0]    cur_depth;
    logic [AW-1:0]    cur_ptr;

    assign cur_base  = base_c[branch_q];
    assign cur_depth = depth_c[branch_q];
    assign cur_ptr   = ptr_q[branch_q];

    assign i_tready = (state_q == ST_RUN) && (!o_tvalid_q || o_tready);
    assign accept   = i_tvalid && i_tready;
    assign ram_beat = accept && !cfg_bypass && (cur_depth != '0);

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (state_q == ST_CLEAR) begin
            ram_we   = 1'b1;
            ram_addr = clr_addr_q;
        end else begin
            ram_we    = ram_beat;
            ram_addr  = cur_base + cur_ptr;
            ram_wdata = i_tdata;
        end
    end

    // Read-first RAM; the read register only moves on an accepted beat, so it holds through stalls.
    always_ff @(posedge ce_clk) begin
        if (ram_beat) ram_rd_q <= mem[ram_addr];
        if (ram_we)   mem[ram_addr] <= ram_wdata;
    end

    always_ff @(posedge ce_clk or posedge ce_rst) begin
        if (ce_rst) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            branch_q   <= '0;
            sync_err_q <= '0;
            o_tvalid_q <= 1'b0;
            o_tlast_q  <= 1'b0;
            sel_ram_q  <= 1'b0;
            dat_q      <= '0;
            for (int i = 0; i < BRANCHES; i++) ptr_q[i] <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_addr_q <= clr_addr_q + AW'(1);
            if (clr_addr_q == LAST_ADDR) begin
                state_q    <= ST_RUN;
                clr_addr_q <= '0;
            end
        end else begin
            if (accept) begin
                o_tvalid_q <= 1'b1;
                o_tlast_q  <= i_tlast;
                if (cfg_bypass || cur_depth == '0) begin
                    dat_q     <= i_tdata;
                    sel_ram_q <= 1'b0;
                end else begin
                    sel_ram_q <= 1'b1;
                end
                if (!cfg_bypass) begin
                    if (cur_depth != '0)
                        ptr_q[branch_q] <= (cur_ptr == cur_depth - AW'(1)) ? '0 : cur_ptr + AW'(1);
                    if ((cfg_resync && i_tlast) || branch_q == LAST_BR)
                        branch_q <= '0;
                    else
                        branch_q <= branch_q + BW'(1);
                    if (i_tlast && branch_q != LAST_BR && sync_err_q != 16'hFFFF)
                        sync_err_q <= sync_err_q + 16'd1;
                end
            end else if (o_tready) begin
                o_tvalid_q <= 1'b0;
            end
        end
    end

    assign o_tdata       = sel_ram_q ? ram_rd_q : dat_q;
    assign o_tvalid      = o_tvalid_q;
    assign o_tlast       = o_tlast_q;
    assign stat_clearing = (state_q == ST_CLEAR);
    assign stat_branch   = branch_q;
    assign stat_sync_err = sync_err_q;

endmodule

// File: tb/tb_atsc_conv_deint.sv
// Directed bench: a B=3/M=1 instance for data ordering, stalls, bypass and saturation,
// and a B=52/M=4 instance for resync, clear length and asynchronous reset.
module tb_atsc_conv_deint;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic        rst3, d3_ivalid, d3_ilast, d3_iready, d3_ovalid, d3_olast, d3_oready;
    logic        d3_byp, d3_rsy, d3_clr;
    logic [31:0] d3_idata, d3_odata;
    logic [1:0]  d3_br;
    logic [15:0] d3_err;

    logic        rst52, d52_ivalid, d52_ilast, d52_iready, d52_ovalid, d52_olast, d52_oready;
    logic        d52_byp, d52_rsy, d52_clr;
    logic [31:0] d52_idata, d52_odata;
    logic [5:0]  d52_br;
    logic [15:0] d52_err;

    logic        m3_vld;
    logic [31:0] m3_dat;

    atsc_conv_deint #(.WIDTH(32), .BRANCHES(3), .DEPTH_INC(1)) u_d3 (
        .ce_clk(clk), .ce_rst(rst3),
        .i_tdata(d3_idata), .i_tvalid(d3_ivalid), .i_tlast(d3_ilast), .i_tready(d3_iready),
        .o_tdata(d3_odata), .o_tvalid(d3_ovalid), .o_tlast(d3_olast), .o_tready(d3_oready),
        .cfg_bypass(d3_byp), .cfg_resync(d3_rsy),
        .stat_clearing(d3_clr), .stat_branch(d3_br), .stat_sync_err(d3_err)
    );

    atsc_conv_deint #(.WIDTH(32), .BRANCHES(52), .DEPTH_INC(4)) u_d52 (
        .ce_clk(clk), .ce_rst(rst52),
        .i_tdata(d52_idata), .i_tvalid(d52_ivalid), .i_tlast(d52_ilast), .i_tready(d52_iready),
        .o_tdata(d52_odata), .o_tvalid(d52_ovalid), .o_tlast(d52_olast), .o_tready(d52_oready),
        .cfg_bypass(d52_byp), .cfg_resync(d52_rsy),
        .stat_clearing(d52_clr), .stat_branch(d52_br), .stat_sync_err(d52_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // B=3, M=1 stream of 1,2,3,... from branch 0: branch b delays by (2-b) visits of 3 beats.
    function automatic logic [31:0] exp3(input int x);
        int b;
        int e;
        b = (x - 1) % 3;
        e = x - 3 * (2 - b);
        return (e > 0) ? 32'(e) : 32'd0;
    endfunction

    task automatic run3(input int first, input int last, input logic [15:0] pat);
        int   idx;
        int   cyc;
        logic acc;
        idx = first;
        cyc = 0;
        while ((idx <= last || m3_vld) && cyc < 64) begin
            d3_ivalid = (idx <= last);
            d3_idata  = 32'(idx);
            d3_oready = pat[cyc % 16];
            acc = d3_ivalid && (!m3_vld || d3_oready);
            #1;
            chk("d3_iready", 32'(d3_iready), 32'(!m3_vld || d3_oready));
            @(posedge clk); #1;
            if (acc) begin
                m3_vld = 1'b1;
                m3_dat = exp3(idx);
                idx++;
            end else if (d3_oready) begin
                m3_vld = 1'b0;
            end
            chk("d3_ovalid", 32'(d3_ovalid), 32'(m3_vld));
            if (m3_vld) chk("d3_odata", d3_odata, m3_dat);
            cyc++;
        end
        d3_ivalid = 1'b0;
        d3_oready = 1'b1;
        chk("d3_stream_done", 32'(idx), 32'(last + 1));
    endtask

    task automatic beat52(input logic [31:0] data, input logic last, input logic [31:0] exp);
        d52_idata  = data;
        d52_ilast  = last;
        d52_ivalid = 1'b1;
        @(posedge clk); #1;
        chk("d52_ovalid", 32'(d52_ovalid), 32'd1);
        chk("d52_odata", d52_odata, exp);
        chk("d52_olast", 32'(d52_olast), 32'(last));
    endtask

    initial begin
        int n;
        logic [31:0] byp_v [3];
        byp_v = '{32'hA5A5_0001, 32'h5A5A_0002, 32'hFFFF_FFFF};

        rst3 = 1'b1; rst52 = 1'b1;
        d3_ivalid = 1'b1; d3_idata = 32'd1; d3_ilast = 1'b0; d3_oready = 1'b1;
        d3_byp = 1'b0; d3_rsy = 1'b0;
        d52_ivalid = 1'b0; d52_idata = '0; d52_ilast = 1'b0; d52_oready = 1'b1;
        d52_byp = 1'b0; d52_rsy = 1'b0;
        m3_vld = 1'b0; m3_dat = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ovalid", 32'(d3_ovalid), 32'd0);
        chk("rst_odata", d3_odata, 32'd0);
        chk("rst_olast", 32'(d3_olast), 32'd0);
        chk("rst_branch", 32'(d3_br), 32'd0);
        chk("rst_syncerr", 32'(d3_err), 32'd0);
        chk("rst_clearing", 32'(d3_clr), 32'd1);
        chk("rst_iready", 32'(d3_iready), 32'd0);
        chk("rst52_clearing", 32'(d52_clr), 32'd1);

        // Clear sweep of TOTAL=3 cycles with i_tvalid held high
        rst3 = 1'b0; rst52 = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("clr3_clearing", 32'(d3_clr), 32'd1);
            chk("clr3_iready", 32'(d3_iready), 32'd0);
            @(posedge clk); #1;
        end
        chk("clr3_done", 32'(d3_clr), 32'd0);
        chk("clr3_iready_run", 32'(d3_iready), 32'd1);

        run3(1, 9, 16'hFFFF);
        chk("d3_branch_after9", 32'(d3_br), 32'd0);

        run3(10, 18, 16'b0110_1001_1100_1001);
        chk("d3_branch_after18", 32'(d3_br), 32'd0);

        d3_byp = 1'b1;
        for (int k = 0; k < 3; k++) begin
            d3_idata  = byp_v[k];
            d3_ilast  = (k == 1);
            d3_ivalid = 1'b1;
            @(posedge clk); #1;
            chk("byp_ovalid", 32'(d3_ovalid), 32'd1);
            chk("byp_odata", d3_odata, byp_v[k]);
            chk("byp_olast", 32'(d3_olast), 32'(k == 1));
            chk("byp_branch", 32'(d3_br), 32'd0);
        end
        d3_ivalid = 1'b0; d3_ilast = 1'b0; d3_byp = 1'b0;
        @(posedge clk); #1;
        chk("byp_drain", 32'(d3_ovalid), 32'd0);
        chk("byp_syncerr", 32'(d3_err), 32'd0);

        run3(19, 27, 16'hFFFF);

        // Resync with tlast every beat keeps branch 0, so every beat is a sync error
        d3_rsy = 1'b1; d3_ilast = 1'b1; d3_ivalid = 1'b1; d3_idata = 32'h55;
        @(posedge clk); #1;
        chk("sat_first", 32'(d3_err), 32'd1);
        chk("sat_branch", 32'(d3_br), 32'd0);
        chk("sat_olast", 32'(d3_olast), 32'd1);
        repeat (65533) @(posedge clk);
        #1;
        chk("sat_fffe", 32'(d3_err), 32'h0000_FFFE);
        @(posedge clk); #1;
        chk("sat_ffff", 32'(d3_err), 32'h0000_FFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_hold", 32'(d3_err), 32'h0000_FFFF);
        d3_ivalid = 1'b0; d3_ilast = 1'b0; d3_rsy = 1'b0;

        n = 0;
        while (d52_clr && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("d52_clear_done", 32'(d52_clr), 32'd0);

        d52_rsy = 1'b1;
        for (int k = 0; k <= 10; k++) beat52(32'h100 + 32'(k), (k == 10), 32'd0);
        chk("resync_err", 32'(d52_err), 32'd1);
        chk("resync_branch", 32'(d52_br), 32'd0);

        d52_rsy = 1'b0;
        for (int k = 0; k <= 10; k++) beat52(32'h200 + 32'(k), (k == 10), 32'd0);
        chk("noresync_err", 32'(d52_err), 32'd2);
        chk("noresync_branch", 32'(d52_br), 32'd11);

        for (int b = 11; b <= 51; b++)
            beat52(32'h300 + 32'(b), 1'b0, (b == 51) ? 32'h300 + 32'(b) : 32'd0);
        beat52(32'h400, 1'b0, 32'd0);
        beat52(32'h401, 1'b0, 32'd0);
        chk("d52_branch_pre_rst", 32'(d52_br), 32'd2);

        // Reset lands mid-cycle while a beat is still on the output
        #2;
        rst52 = 1'b1;
        #1;
        chk("arst_ovalid", 32'(d52_ovalid), 32'd0);
        chk("arst_odata", d52_odata, 32'd0);
        chk("arst_clearing", 32'(d52_clr), 32'd1);
        chk("arst_branch", 32'(d52_br), 32'd0);
        chk("arst_syncerr", 32'(d52_err), 32'd0);
        d52_ivalid = 1'b0;
        @(posedge clk);
        #4;
        rst52 = 1'b0;
        n = 0;
        while (d52_clr && n < 6000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("arst_clear_len", 32'(n), 32'd5304);
        chk("arst_iready", 32'(d52_iready), 32'd1);

        for (int b = 0; b <= 51; b++)
            beat52(32'h500 + 32'(b), 1'b0, (b == 51) ? 32'h500 + 32'(b) : 32'd0);
        d52_ivalid = 1'b0;
        chk("post_clear_branch", 32'(d52_br), 32'd0);
        chk("post_clear_syncerr", 32'(d52_err), 32'd0);

        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
